// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request bus between the MEM stage and data memory.
//
// Signals
//   dmem_req    master->slave  access outstanding
//   dmem_we     master->slave  1 = write, 0 = read
//   dmem_addr   master->slave  word-aligned address
//   dmem_wdata  master->slave  lane-replicated store data
//   dmem_be     master->slave  byte enables
//   dmem_ack    slave->master  access completed this cycle
//   dmem_rdata  slave->master  read data, valid while dmem_ack=1
//
// Handshake: the master raises dmem_req with addr/we/wdata/be and holds all of
// them stable until the rising edge at which dmem_ack=1 is sampled; that edge
// completes the transfer (read data is taken from dmem_rdata at the same edge).
// The master may also withdraw the request after its timeout expires; the slave
// must then treat the access as abandoned.
interface mem_stage_if #(
    parameter int XLEN = 32
);
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_be;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage.
//
// Takes the execute-stage result bundle, performs loads/stores over the
// mem_stage_if request bus, aligns store data / byte enables, extracts and
// extends load data, and registers the writeback bundle for WB. While an
// access is outstanding the stage holds upstream via stall.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   en                   accept a new bundle when en=1 and stall=0
//   en_mem, en_wb        bundle does a memory access / writes a register
//   mem_write            1 = store, 0 = load
//   mem_read_unsigned    loads zero-extend when 1, sign-extend when 0
//   mem_size             00 byte, 01 half, 10 word, 11 illegal
//   reg_write, write_pc  writeback control, passed to WB
//   addr                 effective address, or ALU result when en_mem=0
//   store_data           rs2 value for stores
//   stall                upstream must hold its bundle (state REQ)
//   dmem                 data-memory bus (master side)
//   wb_data, reg_write_out, write_pc_out   registered writeback bundle
//   en_wb_out            one-cycle pulse per retired bundle needing writeback
//   misaligned           one-cycle pulse: misaligned/illegal access dropped
//   bus_err              one-cycle pulse: access aborted on timeout
//   dbg_state            current FSM state (0 = IDLE, 1 = REQ)
module mem_stage #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              en_mem,
    input  logic              en_wb,
    input  logic              mem_write,
    input  logic              mem_read_unsigned,
    input  logic [1:0]        mem_size,
    input  logic [4:0]        reg_write,
    input  logic              write_pc,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   store_data,
    output logic              stall,
    mem_stage_if.master       dmem,
    output logic [XLEN-1:0]   wb_data,
    output logic [4:0]        reg_write_out,
    output logic              en_wb_out,
    output logic              write_pc_out,
    output logic              misaligned,
    output logic              bus_err,
    output logic              dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Bundle captured on REQ entry; drives the bus for the whole access.
    logic [XLEN-1:0] lat_addr;
    logic [XLEN-1:0] lat_sd;
    logic [1:0]      lat_size;
    logic            lat_we;
    logic            lat_uns;
    logic            lat_en_wb;
    logic [4:0]      lat_rw;
    logic            lat_wpc;
    logic [7:0]      cnt_q;

    logic            accept;
    logic            size_ok;
    logic            timeout_hit;
    logic [3:0]      be_c;
    logic [XLEN-1:0] wdata_c;
    logic [XLEN-1:0] rshift;
    logic [XLEN-1:0] load_val;

    assign accept = (state_q == IDLE) && en;

    always_comb begin
        size_ok = 1'b0;
        case (mem_size)
            2'b00:   size_ok = 1'b1;
            2'b01:   size_ok = ~addr[0];
            2'b10:   size_ok = (addr[1:0] == 2'b00);
            default: size_ok = 1'b0;
        endcase
    end

    // cnt_q counts REQ cycles already spent without ack, so cnt_q == TIMEOUT-1
    // marks the TIMEOUT-th cycle; an ack in that cycle still completes.
    assign timeout_hit = (state_q == REQ) && !dmem.dmem_ack && (cnt_q == 8'(TIMEOUT - 1));

    // Store lane steering from the latched bundle (loads reuse the enables).
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = lat_sd;
        case (lat_size)
            2'b00: begin
                be_c    = 4'b0001 << lat_addr[1:0];
                wdata_c = {4{lat_sd[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << lat_addr[1:0];
                wdata_c = {2{lat_sd[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = lat_sd;
            end
        endcase
    end

    // Load extraction: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        rshift   = dmem.dmem_rdata >> {lat_addr[1:0], 3'b000};
        load_val = dmem.dmem_rdata;
        case (lat_size)
            2'b00:   load_val = {{(XLEN-8){~lat_uns & rshift[7]}}, rshift[7:0]};
            2'b01:   load_val = {{(XLEN-16){~lat_uns & rshift[15]}}, rshift[15:0]};
            default: load_val = dmem.dmem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && en_mem && size_ok) state_d = REQ;
            REQ:     if (dmem.dmem_ack || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stall and the bus depend on state only, never on dmem_ack, so there is
    // no combinational path from memory back to the upstream stage.
    assign stall           = (state_q == REQ);
    assign dmem.dmem_req   = stall;
    assign dmem.dmem_we    = stall & lat_we;
    assign dmem.dmem_addr  = stall ? {lat_addr[XLEN-1:2], 2'b00} : '0;
    assign dmem.dmem_wdata = stall ? wdata_c : '0;
    assign dmem.dmem_be    = stall ? be_c : 4'b0000;
    assign dbg_state       = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            lat_addr      <= '0;
            lat_sd        <= '0;
            lat_size      <= 2'b00;
            lat_we        <= 1'b0;
            lat_uns       <= 1'b0;
            lat_en_wb     <= 1'b0;
            lat_rw        <= 5'd0;
            lat_wpc       <= 1'b0;
            cnt_q         <= 8'd0;
            wb_data       <= '0;
            reg_write_out <= 5'd0;
            write_pc_out  <= 1'b0;
            en_wb_out     <= 1'b0;
            misaligned    <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            state_q    <= state_d;
            // Pulses default low so each lasts exactly one cycle.
            en_wb_out  <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            if (state_q == IDLE) begin
                if (en) begin
                    if (!en_mem) begin
                        wb_data       <= addr;
                        reg_write_out <= reg_write;
                        write_pc_out  <= write_pc;
                        en_wb_out     <= en_wb;
                    end else if (!size_ok) begin
                        reg_write_out <= reg_write;
                        write_pc_out  <= write_pc;
                        misaligned    <= 1'b1;
                    end else begin
                        lat_addr  <= addr;
                        lat_sd    <= store_data;
                        lat_size  <= mem_size;
                        lat_we    <= mem_write;
                        lat_uns   <= mem_read_unsigned;
                        lat_en_wb <= en_wb;
                        lat_rw    <= reg_write;
                        lat_wpc   <= write_pc;
                        cnt_q     <= 8'd0;
                    end
                end
            end else begin
                if (dmem.dmem_ack) begin
                    wb_data       <= lat_we ? '0 : load_val;
                    reg_write_out <= lat_rw;
                    write_pc_out  <= lat_wpc;
                    en_wb_out     <= lat_en_wb & ~lat_we;
                end else if (timeout_hit) begin
                    bus_err <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage (TIMEOUT=4).
// Pulse outputs are checked by a negedge monitor against an expected queue;
// bus behaviour and stall length are checked by the driver task.
module tb_mem_stage;

    localparam int W = 43;
    // exp entry: [42] check ctrl, [41] check data, [40:38] {en_wb_out,misaligned,bus_err},
    //            [37] write_pc_out, [36:32] reg_write_out, [31:0] wb_data
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;

    logic        clk;
    logic        rst;
    logic        en, en_mem, en_wb, mem_write, mem_read_unsigned, write_pc;
    logic [1:0]  mem_size;
    logic [4:0]  reg_write;
    logic [31:0] addr, store_data;
    logic        stall;
    logic [31:0] wb_data;
    logic [4:0]  reg_write_out;
    logic        en_wb_out, write_pc_out, misaligned, bus_err, dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    mem_stage_if #(.XLEN(32)) dmem_if ();

    mem_stage #(.XLEN(32), .TIMEOUT(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .en                (en),
        .en_mem            (en_mem),
        .en_wb             (en_wb),
        .mem_write         (mem_write),
        .mem_read_unsigned (mem_read_unsigned),
        .mem_size          (mem_size),
        .reg_write         (reg_write),
        .write_pc          (write_pc),
        .addr              (addr),
        .store_data        (store_data),
        .stall             (stall),
        .dmem              (dmem_if),
        .wb_data           (wb_data),
        .reg_write_out     (reg_write_out),
        .en_wb_out         (en_wb_out),
        .write_pc_out      (write_pc_out),
        .misaligned        (misaligned),
        .bus_err           (bus_err),
        .dbg_state         (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst && (en_wb_out || misaligned || bus_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {29'd0, en_wb_out, misaligned, bus_err}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind", {29'd0, en_wb_out, misaligned, bus_err}, {29'd0, mon_e[40:38]});
                if (mon_e[42]) begin
                    check("reg_write_out", {27'd0, reg_write_out}, {27'd0, mon_e[36:32]});
                    check("write_pc_out", {31'd0, write_pc_out}, {31'd0, mon_e[37]});
                end
                if (mon_e[41]) check("wb_data", wb_data, mon_e[31:0]);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_bundle(
        input string       name,
        input logic        em, ew, we, uns,
        input logic [1:0]  sz,
        input logic [4:0]  rw,
        input logic        wpc,
        input logic [31:0] a, sd, rd,
        input int          ack_at, exp_stall,
        input logic [31:0] exp_addr,
        input logic [3:0]  exp_be,
        input logic [31:0] exp_wdata
    );
        int cyc;
        en = 1'b1; en_mem = em; en_wb = ew; mem_write = we; mem_read_unsigned = uns;
        mem_size = sz; reg_write = rw; write_pc = wpc; addr = a; store_data = sd;
        @(posedge clk); #1;
        en = 1'b0;
        addr = 32'hFFFF_FFFF; store_data = 32'hFFFF_FFFF; mem_size = 2'b11;
        if (exp_stall == 0) check({name, "_no_req"}, {31'd0, dmem_if.dmem_req}, 32'd0);
        cyc = 0;
        while (stall && cyc < 20) begin
            cyc++;
            check({name, "_req"}, {31'd0, dmem_if.dmem_req}, 32'd1);
            check({name, "_we"}, {31'd0, dmem_if.dmem_we}, {31'd0, we});
            check({name, "_addr"}, dmem_if.dmem_addr, exp_addr);
            check({name, "_be"}, {28'd0, dmem_if.dmem_be}, {28'd0, exp_be});
            if (we) check({name, "_wdata"}, dmem_if.dmem_wdata, exp_wdata);
            if (cyc == ack_at) begin
                dmem_if.dmem_ack = 1'b1;
                dmem_if.dmem_rdata = rd;
            end
            @(posedge clk); #1;
            dmem_if.dmem_ack = 1'b0;
            dmem_if.dmem_rdata = 32'h0;
        end
        check({name, "_stall_cycles"}, cyc, exp_stall);
        check({name, "_req_low_after"}, {31'd0, dmem_if.dmem_req}, 32'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0; en = 1'b0; en_mem = 1'b0; en_wb = 1'b0; mem_write = 1'b0;
        mem_read_unsigned = 1'b0; mem_size = 2'b00; reg_write = 5'd0; write_pc = 1'b0;
        addr = 32'h0; store_data = 32'h0;
        dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = 32'h0;
        #1;
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_req", {31'd0, dmem_if.dmem_req}, 32'd0);
        check("reset_wb_data", wb_data, 32'd0);
        check("reset_ctrl", {26'd0, reg_write_out, en_wb_out}, 32'd0);
        check("reset_pulses", {29'd0, write_pc_out, misaligned, bus_err}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // 1 passthrough
        exp_q.push_back({1'b1, 1'b1, 3'b100, 1'b0, 5'd5, 32'h0000_1234});
        run_bundle("pass", 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 5'd5, 1'b0, 32'h1234, 32'h0, 32'h0,
                   0, 0, 32'h0, 4'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1 check("hold_wb_data", wb_data, 32'h0000_1234);
        // passthrough without writeback: no pulse, fields still registered
        run_bundle("pass_nowb", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd31, 1'b1, 32'hCAFE_F00D, 32'h0, 32'h0,
                   0, 0, 32'h0, 4'h0, 32'h0);
        check("pass_nowb_data", wb_data, 32'hCAFE_F00D);
        check("pass_nowb_ctrl", {26'd0, reg_write_out, write_pc_out}, {26'd0, 5'd31, 1'b1});

        // 2 stores
        run_bundle("st_byte", 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 5'd7, 1'b0, 32'h103, 32'h0000_00A5, 32'h0,
                   3, 3, 32'h100, 4'b1000, 32'hA5A5_A5A5);
        check("st_byte_wb_data", wb_data, 32'h0);
        check("st_byte_rw", {27'd0, reg_write_out}, 32'd7);
        run_bundle("st_half", 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 5'd8, 1'b0, 32'h2, 32'h1234_BEEF, 32'h0,
                   1, 1, 32'h0, 4'b1100, 32'hBEEF_BEEF);
        run_bundle("st_word", 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 5'd9, 1'b0, 32'h10, 32'h0BAD_F00D, 32'h0,
                   2, 2, 32'h10, 4'b1111, 32'h0BAD_F00D);

        // 3 loads
        exp_q.push_back({1'b1, 1'b1, 3'b100, 1'b0, 5'd3, 32'hFFFF_80FF});
        run_bundle("ld_half_s", 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 5'd3, 1'b0, 32'h202, 32'h0, 32'h80FF_1234,
                   1, 1, 32'h200, 4'b1100, 32'h0);
        exp_q.push_back({1'b1, 1'b1, 3'b100, 1'b1, 5'd4, 32'h0000_80FF});
        run_bundle("ld_half_u", 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 5'd4, 1'b1, 32'h202, 32'h0, 32'h80FF_1234,
                   1, 1, 32'h200, 4'b1100, 32'h0);
        exp_q.push_back({1'b1, 1'b1, 3'b100, 1'b0, 5'd10, 32'hFFFF_FF80});
        run_bundle("ld_byte_s", 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 5'd10, 1'b0, 32'h401, 32'h0, 32'h1234_8056,
                   2, 2, 32'h400, 4'b0010, 32'h0);
        exp_q.push_back({1'b1, 1'b1, 3'b100, 1'b0, 5'd11, 32'h0000_00AB});
        run_bundle("ld_byte_u", 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 5'd11, 1'b0, 32'h403, 32'h0, 32'hAB00_0000,
                   1, 1, 32'h400, 4'b1000, 32'h0);

        // 4 misaligned / illegal
        exp_q.push_back({1'b1, 1'b0, 3'b010, 1'b1, 5'd12, 32'h0});
        run_bundle("mis_word", 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 5'd12, 1'b1, 32'h6, 32'h0, 32'h0,
                   0, 0, 32'h0, 4'h0, 32'h0);
        exp_q.push_back({1'b1, 1'b0, 3'b010, 1'b0, 5'd13, 32'h0});
        run_bundle("mis_half", 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 5'd13, 1'b0, 32'h1, 32'h0, 32'h0,
                   0, 0, 32'h0, 4'h0, 32'h0);
        exp_q.push_back({1'b1, 1'b0, 3'b010, 1'b0, 5'd14, 32'h0});
        run_bundle("mis_size3", 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 5'd14, 1'b0, 32'h0, 32'h0, 32'h0,
                   0, 0, 32'h0, 4'h0, 32'h0);

        // 5 timeout, then ack in the last allowed cycle
        exp_q.push_back({1'b0, 1'b0, 3'b001, 1'b0, 5'd0, 32'h0});
        run_bundle("timeout", 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 5'd15, 1'b0, 32'h300, 32'h0, 32'h0,
                   0, 4, 32'h300, 4'b1111, 32'h0);
        exp_q.push_back({1'b1, 1'b1, 3'b100, 1'b0, 5'd16, 32'hDEAD_BEEF});
        run_bundle("ack_last", 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 5'd16, 1'b0, 32'h300, 32'h0, 32'hDEAD_BEEF,
                   4, 4, 32'h300, 4'b1111, 32'h0);

        // 6 async reset mid-REQ
        en = 1'b1; en_mem = 1'b1; en_wb = 1'b1; mem_write = 1'b0; mem_size = 2'b10;
        reg_write = 5'd17; addr = 32'h500;
        @(posedge clk); #1;
        en = 1'b0;
        check("rst_pre_req", {31'd0, dmem_if.dmem_req}, 32'd1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("rst_req", {31'd0, dmem_if.dmem_req}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_reg_write_out", {27'd0, reg_write_out}, 32'd0);
        check("rst_state", {31'd0, dbg_state}, 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back({1'b1, 1'b1, 3'b100, 1'b0, 5'd9, 32'h0000_55AA});
        run_bundle("pass_after_rst", 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 5'd9, 1'b0, 32'h55AA, 32'h0, 32'h0,
                   0, 0, 32'h0, 4'h0, 32'h0);

        repeat (3) @(posedge clk);
        #1 check("scoreboard_drain", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
